dmem_arbiter: RTL and testbench

- Shares the single-ported data memory between two requesters: the pipeline memory-access stage (port MA) and the program/debug loader (port LD).
- Sequences each access through a fixed-latency memory: issue, wait, capture, respond. Drives a stall to the pipeline while an MA access is pending.
- Sits between the MA stage / loader and data_memory. Arbitration is 2-way round-robin.

---
 rtl/dmem_arb_pkg.sv | 24 ++
 rtl/dmem_req_if.sv | 16 +
 rtl/dmem_rr_picker.sv | 23 ++
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned LAT_W  = 4;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_MA = 1'b0,
    PORT_LD = 1'b1
  } port_id_e;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_req_if.sv
// Requester-side handshake bundle: one instance per port (MA stage, loader).
interface dmem_req_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 64
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              stall_c;

  modport master (output req, we, addr, wdata, input done, rdata, stall_c);
  modport slave  (input req, we, addr, wdata, output done, rdata, stall_c);
endinterface

// File: rtl/dmem_rr_picker.sv
// 2-way round-robin choice between MA and LD requests.
module dmem_rr_picker
  import dmem_arb_pkg::*;
(
  input  logic     ma_req_i,
  input  logic     ld_req_i,
  input  port_id_e last_i,
  output port_id_e grant_c_o,
  output logic     valid_c_o
);

  // On a conflict the port not granted last wins; otherwise the lone requester.
  always_comb begin
    grant_c_o = PORT_MA;
    valid_c_o = ma_req_i | ld_req_i;
    if (ma_req_i && ld_req_i) begin
      grant_c_o = (last_i == PORT_MA) ? PORT_LD : PORT_MA;
    end else if (ld_req_i) begin
      grant_c_o = PORT_LD;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-ported data memory between the MA stage and the loader.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE against a fixed-latency memory.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_req_if.slave         ma,
  dmem_req_if.slave         ld,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [STAT_W-1:0] conflict_cnt_o,
  output logic [STAT_W-1:0] ma_wait_cnt_o
);

  arb_state_e        state_q, state_d;
  port_id_e          port_q, port_d;
  port_id_e          last_q, last_d;
  port_id_e          grant_c;
  logic              grant_vld_c;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ma_done_q, ma_done_d;
  logic              ld_done_q, ld_done_d;
  logic [DATA_W-1:0] ma_rdata_q, ma_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic [DATA_W-1:0] capture_c;

  dmem_rr_picker u_picker (
    .ma_req_i  (ma.req),
    .ld_req_i  (ld.req),
    .last_i    (last_q),
    .grant_c_o (grant_c),
    .valid_c_o (grant_vld_c)
  );

  // Stores return zero; loads return the memory word.
  assign capture_c = we_q ? '0 : mem_rdata_i;

  // Next-state logic; registered outputs are derived from the next state.
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    ma_rdata_d = ma_rdata_q;
    ld_rdata_d = ld_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld_c) begin
          port_d  = grant_c;
          state_d = ST_ISSUE;
          if (grant_c == PORT_MA) begin
            we_d    = ma.we;
            addr_d  = ma.addr;
            wdata_d = ma.wdata;
          end else begin
            we_d    = ld.we;
            addr_d  = ld.addr;
            wdata_d = ld.wdata;
          end
        end
      end
      ST_ISSUE: begin
        lat_d   = LAT_W'(MEM_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q <= LAT_W'(1)) begin
          if (port_q == PORT_MA) begin
            ma_rdata_d = capture_c;
          end else begin
            ld_rdata_d = capture_c;
          end
          state_d = ST_DONE;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_DONE: begin
        last_d  = port_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    mem_en_d    = (state_d == ST_ISSUE);
    mem_we_d    = mem_en_d & we_d;
    mem_addr_d  = mem_en_d ? addr_d : '0;
    mem_wdata_d = mem_en_d ? wdata_d : '0;
    ma_done_d   = (state_d == ST_DONE) && (port_d == PORT_MA);
    ld_done_d   = (state_d == ST_DONE) && (port_d == PORT_LD);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_MA;
      last_q      <= PORT_LD;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ma_done_q   <= 1'b0;
      ld_done_q   <= 1'b0;
      ma_rdata_q  <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ma_done_q   <= ma_done_d;
      ld_done_q   <= ld_done_d;
      ma_rdata_q  <= ma_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  assign ma.done    = ma_done_q;
  assign ma.rdata   = ma_rdata_q;
  assign ma.stall_c = ma.req & ~ma_done_q;
  assign ld.done    = ld_done_q;
  assign ld.rdata   = ld_rdata_q;
  assign ld.stall_c = ld.req & ~ld_done_q;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic [STAT_W-1:0] ma_wait_cnt_q, ma_wait_cnt_d;

  // Count IDLE-cycle conflicts and MA stall cycles, saturating.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    ma_wait_cnt_d  = ma_wait_cnt_q;
    if ((state_q == ST_IDLE) && ma.req && ld.req) begin
      conflict_cnt_d = sat_inc(conflict_cnt_q);
    end
    if (ma.stall_c) begin
      ma_wait_cnt_d = sat_inc(ma_wait_cnt_q);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt_q <= '0;
      ma_wait_cnt_q  <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      ma_wait_cnt_q  <= ma_wait_cnt_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign ma_wait_cnt_o  = ma_wait_cnt_q;
`else
  assign conflict_cnt_o = '0;
  assign ma_wait_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: MEM_LAT=1 instance plus a MEM_LAT=4 instance.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 64;

`ifdef DMEM_ARB_STATS_EN
  localparam logic [15:0] EXP_CONF  = 16'd1;
  localparam logic [15:0] EXP_WAIT  = 16'd3;
  localparam logic [15:0] EXP_WAIT2 = 16'd6;
`else
  localparam logic [15:0] EXP_CONF  = 16'd0;
  localparam logic [15:0] EXP_WAIT  = 16'd0;
  localparam logic [15:0] EXP_WAIT2 = 16'd0;
`endif

  typedef struct {
    int          ch;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   en2_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_req_if #(.ADDR_W(AW), .DATA_W(DW)) ma1 (), ld1 (), ma2 (), ld2 ();

  logic          mem_en1, mem_we1, mem_en2, mem_we2;
  logic [AW-1:0] mem_addr1, mem_addr2;
  logic [DW-1:0] mem_wdata1, mem_rdata1, mem_wdata2, mem_rdata2;
  logic [15:0]   conf1, wait1, conf2, wait2;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .ma(ma1), .ld(ld1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata1),
    .conflict_cnt_o(conf1), .ma_wait_cnt_o(wait1)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .ma(ma2), .ld(ld2),
    .mem_en_o(mem_en2), .mem_we_o(mem_we2), .mem_addr_o(mem_addr2),
    .mem_wdata_o(mem_wdata2), .mem_rdata_i(mem_rdata2),
    .conflict_cnt_o(conf2), .ma_wait_cnt_o(wait2)
  );

  // Memory for the MEM_LAT=1 instance; 0x17 is preloaded on reset.
  logic [DW-1:0] mem1 [256];
  always @(posedge clk) begin
    if (rst) mem1[8'h17] <= 64'h0F;
    if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
    mem_rdata1 <= (mem_en1 && !mem_we1) ? mem1[mem_addr1] : '0;
  end

  // MEM_LAT=4 memory: address-derived data, valid for one cycle only.
  logic [DW-1:0] pipe2 [4];
  always @(posedge clk) begin
    pipe2[0] <= (mem_en2 && !mem_we2) ? (64'hC0DE_0000_0000_0000 | DW'(mem_addr2)) : '0;
    for (int i = 1; i < 4; i++) pipe2[i] <= pipe2[i-1];
  end
  assign mem_rdata2 = pipe2[3];

  always @(negedge clk) if (mem_en2 === 1'b1) en2_cnt = en2_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic mon_ch(input int ch, input string nm, input logic done, input logic [63:0] rd);
    int idx = -1;
    if (done === 1'b1) begin
      foreach (sb[i]) if (idx < 0 && sb[i].ch == ch) idx = i;
      if (idx < 0) begin
        total++;
        bad++;
        $display("FAIL %s_unexpected_done: got done at cycle %0d want none", nm, cyc);
      end else begin
        chk({nm, "_rdata"}, rd, sb[idx].rdata);
        chk({nm, "_done_cycle"}, 64'(cyc), 64'(sb[idx].cyc));
        sb.delete(idx);
      end
    end
  endtask

  // Monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon_ch(0, "ma1", ma1.done, ma1.rdata);
      mon_ch(1, "ld1", ld1.done, ld1.rdata);
      mon_ch(2, "ma2", ma2.done, ma2.rdata);
      mon_ch(3, "ld2", ld2.done, ld2.rdata);
    end
  end

  function automatic logic done_of(input int ch);
    case (ch)
      0:       return ma1.done;
      1:       return ld1.done;
      2:       return ma2.done;
      default: return ld2.done;
    endcase
  endfunction

  task automatic drive(input int ch, input logic w, input logic [7:0] a, input logic [63:0] d);
    case (ch)
      0:       begin ma1.req = 1'b1; ma1.we = w; ma1.addr = a; ma1.wdata = d; end
      1:       begin ld1.req = 1'b1; ld1.we = w; ld1.addr = a; ld1.wdata = d; end
      default: begin ma2.req = 1'b1; ma2.we = w; ma2.addr = a; ma2.wdata = d; end
    endcase
  endtask

  task automatic drop(input int ch);
    case (ch)
      0:       ma1.req = 1'b0;
      1:       ld1.req = 1'b0;
      default: ma2.req = 1'b0;
    endcase
  endtask

  task automatic expect_done(input int ch, input logic [63:0] rd, input int at);
    exp_t e;
    e.ch = ch;
    e.rdata = rd;
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int ch);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_of(ch) !== 1'b1 && n < 40);
    if (done_of(ch) !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL wait_done_ch%0d: got no done after %0d cycles want done", ch, n);
    end
  endtask

  task automatic access(input int ch, input logic w, input logic [7:0] a, input logic [63:0] d,
                        input logic [63:0] exp, input int lat);
    drive(ch, w, a, d);
    expect_done(ch, exp, cyc + lat);
    wait_done(ch);
    @(posedge clk); #1;
    drop(ch);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rst = 1'b1;
    ma1.req = 1'b0; ma1.we = 1'b0; ma1.addr = '0; ma1.wdata = '0;
    ld1.req = 1'b0; ld1.we = 1'b0; ld1.addr = '0; ld1.wdata = '0;
    ma2.req = 1'b0; ma2.we = 1'b0; ma2.addr = '0; ma2.wdata = '0;
    ld2.req = 1'b0; ld2.we = 1'b0; ld2.addr = '0; ld2.wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_en", 64'(mem_en1), 64'd0);
    chk("rst_mem_we", 64'(mem_we1), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr1), 64'd0);
    chk("rst_mem_wdata", mem_wdata1, 64'd0);
    chk("rst_ma_done", 64'(ma1.done), 64'd0);
    chk("rst_ld_done", 64'(ld1.done), 64'd0);
    chk("rst_ma_rdata", ma1.rdata, 64'd0);
    chk("rst_ld_rdata", ld1.rdata, 64'd0);
    chk("rst_conflict_cnt", 64'(conf1), 64'd0);
    chk("rst_ma_wait_cnt", 64'(wait1), 64'd0);

    // Single MA load of 0x17
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h17, 64'h0);
    t0 = cyc;
    expect_done(0, 64'h0F, t0 + 3);
    @(negedge clk);
    chk("t1_c0_stall", 64'(ma1.stall_c), 64'd1);
    chk("t1_c0_mem_en", 64'(mem_en1), 64'd0);
    @(negedge clk);
    chk("t1_c1_mem_en", 64'(mem_en1), 64'd1);
    chk("t1_c1_mem_addr", 64'(mem_addr1), 64'h17);
    chk("t1_c1_mem_we", 64'(mem_we1), 64'd0);
    chk("t1_c1_stall", 64'(ma1.stall_c), 64'd1);
    @(negedge clk);
    chk("t1_c2_mem_en", 64'(mem_en1), 64'd0);
    chk("t1_c2_stall", 64'(ma1.stall_c), 64'd1);
    wait_done(0);
    chk("t1_c3_stall", 64'(ma1.stall_c), 64'd0);
    @(posedge clk); #1;
    drop(0);
    @(posedge clk); #1;

    // MA store 0x05 <- 9, then read it back
    drive(0, 1'b1, 8'h05, 64'h9);
    expect_done(0, 64'h0, cyc + 3);
    @(negedge clk);
    @(negedge clk);
    chk("t2_mem_en", 64'(mem_en1), 64'd1);
    chk("t2_mem_we", 64'(mem_we1), 64'd1);
    chk("t2_mem_addr", 64'(mem_addr1), 64'h05);
    chk("t2_mem_wdata", mem_wdata1, 64'h9);
    wait_done(0);
    @(posedge clk); #1;
    drop(0);
    @(posedge clk); #1;
    access(0, 1'b0, 8'h05, 64'h0, 64'h9, 3);

    // Loader store with req dropped after one cycle still completes
    drive(1, 1'b1, 8'h20, 64'h55);
    expect_done(1, 64'h0, cyc + 3);
    @(posedge clk); #1;
    drop(1);
    wait_done(1);
    @(posedge clk); #1;
    access(0, 1'b0, 8'h20, 64'h0, 64'h55, 3);

    // Conflict right after reset: MA first, then LD
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b0, 8'h17, 64'h0);
    drive(1, 1'b0, 8'h05, 64'h0);
    t0 = cyc;
    expect_done(0, 64'h0F, t0 + 3);
    expect_done(1, 64'h9, t0 + 7);
    wait_done(0);
    @(posedge clk); #1;
    drop(0);
    wait_done(1);
    @(posedge clk); #1;
    drop(1);
    @(negedge clk);
    chk("conflict_cnt", 64'(conf1), 64'(EXP_CONF));
    chk("ma_wait_cnt", 64'(wait1), 64'(EXP_WAIT));
    @(posedge clk); #1;

    // Repeat conflict: MA wins again
    drive(0, 1'b0, 8'h05, 64'h0);
    drive(1, 1'b0, 8'h20, 64'h0);
    t0 = cyc;
    expect_done(0, 64'h9, t0 + 3);
    expect_done(1, 64'h55, t0 + 7);
    wait_done(0);
    @(posedge clk); #1;
    drop(0);
    wait_done(1);
    @(posedge clk); #1;
    drop(1);
    @(posedge clk); #1;

    // Reset during cycle 2 of an MA load: no done, then a clean access
    drive(0, 1'b0, 8'h17, 64'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    drop(0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ma_done", 64'(ma1.done), 64'd0);
    chk("rst_mid_ma_rdata", ma1.rdata, 64'd0);
    chk("rst_mid_ld_rdata", ld1.rdata, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_mem_en", 64'(mem_en1), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    access(0, 1'b0, 8'h17, 64'h0, 64'h0F, 3);

    // MEM_LAT=4 instance: done at cycle 6, one mem_en pulse
    drive(2, 1'b0, 8'h3C, 64'h0);
    expect_done(2, 64'hC0DE_0000_0000_003C, cyc + 6);
    wait_done(2);
    @(posedge clk); #1;
    drop(2);
    @(negedge clk);
    chk("lat4_mem_en_pulses", 64'(en2_cnt), 64'd1);
    chk("lat4_ma_wait_cnt", 64'(wait2), 64'(EXP_WAIT2));
    chk("lat4_conflict_cnt", 64'(conf2), 64'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
